// File: rtl/pwm_multi_gen_if.sv
// Register-file side of the PWM engine: generator/pin configuration in, pin levels and period ticks out.
// With PWM_CENTER_ALIGN_EN defined, a per-generator gen_mode select is added.
interface pwm_multi_gen_if #(
    parameter int NUM_GEN    = 2,
    parameter int CH_PER_GEN = 2,
    parameter int NUM_OUT    = 8,
    parameter int CNT_W      = 8
);
    localparam int NCH   = NUM_GEN * CH_PER_GEN;
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    // Plain level-held configuration: no valid/ready; the engine samples every input every cycle.
    logic [NUM_GEN-1:0]         gen_en;
    logic [4*NUM_GEN-1:0]       gen_div;
    logic [CNT_W*NUM_GEN-1:0]   gen_top;
    logic [CNT_W*NCH-1:0]       duty;
    logic [NUM_OUT-1:0]         out_en;
    logic [NUM_OUT-1:0]         out_pwm_en;
    logic [SEL_W*NUM_OUT-1:0]   out_sel;
    logic [NUM_OUT-1:0]         out_inv;
`ifdef PWM_CENTER_ALIGN_EN
    logic [NUM_GEN-1:0]         gen_mode;
`endif
    logic [NUM_OUT-1:0]         out;
    logic [NUM_GEN-1:0]         period_tick;

    modport master (
`ifdef PWM_CENTER_ALIGN_EN
        output gen_mode,
`endif
        output gen_en, gen_div, gen_top, duty, out_en, out_pwm_en, out_sel, out_inv,
        input  out, period_tick
    );

    modport slave (
`ifdef PWM_CENTER_ALIGN_EN
        input  gen_mode,
`endif
        input  gen_en, gen_div, gen_top, duty, out_en, out_pwm_en, out_sel, out_inv,
        output out, period_tick
    );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-generator PWM engine: prescaled period counters, double-buffered duty, registered pin crossbar.
// Define PWM_CENTER_ALIGN_EN to add per-generator center-aligned (up/down) counting via gen_mode.
module pwm_multi_gen #(
    parameter int NUM_GEN    = 2,
    parameter int CH_PER_GEN = 2,
    parameter int NUM_OUT    = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_multi_gen_if.slave   bus
);
    localparam int NCH   = NUM_GEN * CH_PER_GEN;
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [15:0]        presc_q   [NUM_GEN];
    logic [15:0]        presc_d   [NUM_GEN];
    logic [CNT_W-1:0]   cnt_q     [NUM_GEN];
    logic [CNT_W-1:0]   cnt_d     [NUM_GEN];
    logic [CNT_W-1:0]   top_sh_q  [NUM_GEN];
    logic [CNT_W-1:0]   top_sh_d  [NUM_GEN];
    logic [CNT_W-1:0]   duty_sh_q [NCH];
    logic [CNT_W-1:0]   duty_sh_d [NCH];
    logic [NUM_GEN-1:0] tick_q, tick_d;
    logic [NUM_OUT-1:0] out_q, out_d;
`ifdef PWM_CENTER_ALIGN_EN
    logic [NUM_GEN-1:0] dir_q, dir_d;   // 0 = counting up
`endif

    logic [15:0]        term      [NUM_GEN];
    logic [CNT_W-1:0]   top_in    [NUM_GEN];
    logic [NUM_GEN-1:0] presc_hit;
    logic [NUM_GEN-1:0] wrap;
    logic [NCH-1:0]     pwm;
    logic [SEL_W-1:0]   pin_sel   [NUM_OUT];
    logic [NUM_OUT-1:0] pin_src;
    logic [NUM_OUT-1:0] pin_lvl;

    // >= rather than == so a shrinking div does not wait for a 16-bit rollover.
    always_comb begin
        for (int g = 0; g < NUM_GEN; g++) begin
            top_in[g]    = bus.gen_top[CNT_W*g +: CNT_W];
            term[g]      = (16'd1 << bus.gen_div[4*g +: 4]) - 16'd1;
            presc_hit[g] = (presc_q[g] >= term[g]);
        end
    end

    always_comb begin
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        top_sh_d  = top_sh_q;
        duty_sh_d = duty_sh_q;
        wrap      = '0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d     = dir_q;
`endif
        for (int g = 0; g < NUM_GEN; g++) begin
            if (!bus.gen_en[g]) begin
                presc_d[g] = '0;
                cnt_d[g]   = '0;
`ifdef PWM_CENTER_ALIGN_EN
                dir_d[g]   = 1'b0;
`endif
            end else if (presc_hit[g]) begin
                presc_d[g] = '0;
`ifdef PWM_CENTER_ALIGN_EN
                if (bus.gen_mode[g]) begin
                    // Period boundary is the bottom turnaround; the next top comes from the fresh shadow.
                    if (!dir_q[g] && cnt_q[g] == '0) begin
                        wrap[g]  = 1'b1;
                        cnt_d[g] = (top_in[g] == '0) ? '0 : CNT_W'(1);
                    end else if (!dir_q[g] && cnt_q[g] < top_sh_q[g]) begin
                        cnt_d[g] = cnt_q[g] + CNT_W'(1);
                    end else begin
                        cnt_d[g] = cnt_q[g] - CNT_W'(1);
                        dir_d[g] = (cnt_q[g] > CNT_W'(1));
                    end
                end else begin
                    dir_d[g] = 1'b0;
                    if (cnt_q[g] == top_sh_q[g]) begin
                        wrap[g]  = 1'b1;
                        cnt_d[g] = '0;
                    end else begin
                        cnt_d[g] = cnt_q[g] + CNT_W'(1);
                    end
                end
`else
                if (cnt_q[g] == top_sh_q[g]) begin
                    wrap[g]  = 1'b1;
                    cnt_d[g] = '0;
                end else begin
                    cnt_d[g] = cnt_q[g] + CNT_W'(1);
                end
`endif
            end else begin
                presc_d[g] = presc_q[g] + 16'd1;
            end

            if (!bus.gen_en[g] || wrap[g]) begin
                top_sh_d[g] = top_in[g];
                for (int c = 0; c < CH_PER_GEN; c++) begin
                    duty_sh_d[g*CH_PER_GEN+c] = bus.duty[CNT_W*(g*CH_PER_GEN+c) +: CNT_W];
                end
            end
        end
        tick_d = wrap;
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            pwm[k] = bus.gen_en[k/CH_PER_GEN] & (cnt_q[k/CH_PER_GEN] < duty_sh_q[k]);
        end
    end

    // Unmatched select codes fall through to a constant 0 source.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            pin_sel[o] = bus.out_sel[SEL_W*o +: SEL_W];
            pin_src[o] = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (pin_sel[o] == SEL_W'(k)) pin_src[o] = pwm[k];
            end
            pin_lvl[o] = bus.out_pwm_en[o] ? pin_src[o] : 1'b1;
            out_d[o]   = bus.out_en[o] & (pin_lvl[o] ^ bus.out_inv[o]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GEN; g++) begin
                presc_q[g]  <= '0;
                cnt_q[g]    <= '0;
                top_sh_q[g] <= '0;
            end
            for (int k = 0; k < NCH; k++) duty_sh_q[k] <= '0;
            tick_q <= '0;
            out_q  <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q  <= '0;
`endif
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            top_sh_q  <= top_sh_d;
            duty_sh_q <= duty_sh_d;
            tick_q    <= tick_d;
            out_q     <= out_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign bus.out         = out_q;
    assign bus.period_tick = tick_q;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: pin table, directed double-buffer/reset sequences, random segments vs arithmetic model.
// Center-aligned checks are included when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_multi_gen;
    localparam int NG  = 2;
    localparam int CH  = 2;
    localparam int NO  = 8;
    localparam int W   = 8;
    localparam int NCH = NG * CH;
    localparam int SW  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_multi_gen_if #(.NUM_GEN(NG), .CH_PER_GEN(CH), .NUM_OUT(NO), .CNT_W(W)) bus ();

    pwm_multi_gen #(.NUM_GEN(NG), .CH_PER_GEN(CH), .NUM_OUT(NO), .CNT_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    // Generator config is held constant over a segment; m counts enabled clock edges in the segment.
    int div_c  [NG];
    int top_c  [NG];
    int duty_c [NCH];
    bit en_c   [NG];
    bit mode_c [NG];
    int m_cnt;

    int checks = 0;
    int errors = 0;
    logic [NO-1:0] exp_q[$];

    // Counter value after j prescaler-clock edges of an enabled generator.
    function automatic int cnt_at(int g, int j);
        int p, n, len, r;
        p = 1 << div_c[g];
        n = j / p;
        if (mode_c[g]) begin
            if (top_c[g] == 0) return 0;
            len = 2 * top_c[g];
            r = n % len;
            return (r <= top_c[g]) ? r : (len - r);
        end
        return n % (top_c[g] + 1);
    endfunction

    function automatic bit pwm_at(int ch, int m);
        int g;
        if (ch >= NCH || m < 1) return 1'b0;
        g = ch / CH;
        if (!en_c[g]) return 1'b0;
        return cnt_at(g, m - 1) < duty_c[ch];
    endfunction

    function automatic bit tick_at(int g, int m);
        int p, n;
        if (!en_c[g] || m < 1) return 1'b0;
        p = 1 << div_c[g];
        if (((m - 1) % p) != p - 1) return 1'b0;
        n = (m - 1) / p;
        if (mode_c[g]) return (top_c[g] == 0) || (n % (2 * top_c[g]) == 0);
        return (n % (top_c[g] + 1)) == top_c[g];
    endfunction

    function automatic logic [NO-1:0] exp_out(int m);
        logic [NO-1:0] r;
        for (int o = 0; o < NO; o++) begin
            int  sel;
            bit  lvl;
            sel  = int'(bus.out_sel[SW*o +: SW]);
            lvl  = bus.out_pwm_en[o] ? pwm_at(sel, m) : 1'b1;
            r[o] = bus.out_en[o] & (lvl ^ bus.out_inv[o]);
        end
        return r;
    endfunction

    function automatic logic [NG-1:0] exp_tick(int m);
        logic [NG-1:0] r;
        for (int g = 0; g < NG; g++) r[g] = tick_at(g, m);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int g = 0; g < NG; g++) begin
            bus.gen_div[4*g +: 4] = 4'(div_c[g]);
            bus.gen_top[W*g +: W] = 8'(top_c[g]);
`ifdef PWM_CENTER_ALIGN_EN
            bus.gen_mode[g] = mode_c[g];
`endif
        end
        for (int k = 0; k < NCH; k++) bus.duty[W*k +: W] = 8'(duty_c[k]);
    endtask

    task automatic clear_cfg();
        for (int g = 0; g < NG; g++) begin
            div_c[g] = 0; top_c[g] = 0; en_c[g] = 1'b0; mode_c[g] = 1'b0;
        end
        for (int k = 0; k < NCH; k++) duty_c[k] = 0;
        bus.out_en = '0; bus.out_pwm_en = '0; bus.out_inv = '0; bus.out_sel = '0;
    endtask

    task automatic rand_pins();
        bus.out_en     = 8'($urandom);
        bus.out_pwm_en = 8'($urandom);
        bus.out_inv    = 8'($urandom);
        bus.out_sel    = 16'($urandom);
    endtask

    // One disabled edge loads shadows and zeroes counters, then the modelled enables apply.
    task automatic start_seg();
        bus.gen_en = '0;
        apply_cfg();
        @(posedge clk); #1;
        m_cnt = 0;
        check("seg_start_out", 32'(bus.out), 32'(exp_out(0)));
        check("seg_start_tick", 32'(bus.period_tick), 32'd0);
        for (int g = 0; g < NG; g++) bus.gen_en[g] = en_c[g];
    endtask

    task automatic step_model(input string name);
        @(posedge clk); #1;
        m_cnt++;
        check({name, "_out"}, 32'(bus.out), 32'(exp_out(m_cnt)));
        check({name, "_tick"}, 32'(bus.period_tick), 32'(exp_tick(m_cnt)));
    endtask

    // Drains the expected queue one clock at a time; gen0 tick expected every tick_per clocks.
    task automatic run_q(input string name, input int tick_per);
        logic [NO-1:0] e;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            m_cnt++;
            e = exp_q.pop_front();
            check({name, "_out"}, 32'(bus.out), 32'(e));
            check({name, "_tick0"}, 32'(bus.period_tick[0]), 32'((m_cnt % tick_per) == 0));
        end
    endtask

    task automatic push_n(input int n, input logic [NO-1:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // ---------------- pin table ----------------
    typedef struct {
        bit g1_en;
        bit en;
        bit pwm;
        bit inv;
        int sel;
        bit exp;
    } pin_vec_t;

    pin_vec_t tbl[8];

`ifdef PWM_CENTER_ALIGN_EN
    int cseq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
`endif

    // ---------------- stimulus ----------------
    initial begin
        int hi0, hi5, tk0, tk1;

        tbl[0] = '{g1_en: 0, en: 1, pwm: 0, inv: 0, sel: 0, exp: 1};
        tbl[1] = '{g1_en: 0, en: 1, pwm: 0, inv: 1, sel: 0, exp: 0};
        tbl[2] = '{g1_en: 0, en: 0, pwm: 0, inv: 1, sel: 0, exp: 0};
        tbl[3] = '{g1_en: 0, en: 1, pwm: 1, inv: 0, sel: 3, exp: 0};
        tbl[4] = '{g1_en: 0, en: 1, pwm: 1, inv: 1, sel: 3, exp: 1};
        tbl[5] = '{g1_en: 1, en: 1, pwm: 1, inv: 0, sel: 3, exp: 1};
        tbl[6] = '{g1_en: 1, en: 1, pwm: 1, inv: 0, sel: 2, exp: 0};
        tbl[7] = '{g1_en: 1, en: 1, pwm: 1, inv: 1, sel: 2, exp: 1};

        // Reset held with random configuration.
        clear_cfg();
        bus.gen_en = 2'($urandom);
        bus.gen_div = '0;
        bus.gen_top = 16'($urandom);
        bus.duty = 32'($urandom);
`ifdef PWM_CENTER_ALIGN_EN
        bus.gen_mode = '0;
`endif
        rand_pins();
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("reset_out", 32'(bus.out), 32'd0);
            check("reset_tick", 32'(bus.period_tick), 32'd0);
            rand_pins();
        end

        // Released with generators off: only static pins can be driven.
        bus.gen_en = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_pins();
            @(posedge clk); #1;
            check("idle_out", 32'(bus.out), 32'(exp_out(0)));
            check("idle_tick", 32'(bus.period_tick), 32'd0);
        end

        // gen0 div0 top9 duty3 on pin0; gen1 div2 top3 duty2 on pin5.
        clear_cfg();
        div_c[0] = 0; top_c[0] = 9; duty_c[0] = 3; en_c[0] = 1'b1;
        div_c[1] = 2; top_c[1] = 3; duty_c[2] = 2; en_c[1] = 1'b1;
        bus.out_en = 8'h21; bus.out_pwm_en = 8'h21;
        bus.out_sel[SW*0 +: SW] = 2'd0;
        bus.out_sel[SW*5 +: SW] = 2'd2;
        start_seg();
        hi0 = 0; hi5 = 0; tk0 = 0; tk1 = 0;
        for (int i = 1; i <= 32; i++) begin
            step_model("basic");
            if (i <= 30) begin
                hi0 += int'(bus.out[0]);
                tk0 += int'(bus.period_tick[0]);
            end
            if (i <= 16) hi5 += int'(bus.out[5]);
            tk1 += int'(bus.period_tick[1]);
        end
        check("pin0_high_count", 32'(hi0), 32'd9);
        check("pin5_high_count", 32'(hi5), 32'd8);
        check("gen0_tick_count", 32'(tk0), 32'd3);
        check("gen1_tick_count", 32'(tk1), 32'd2);

        // Duty double-buffering, duty > top and duty = 0, write coinciding with wrap.
        clear_cfg();
        top_c[0] = 9; duty_c[0] = 3; en_c[0] = 1'b1;
        bus.out_en = 8'h01; bus.out_pwm_en = 8'h01;
        start_seg();
        push_n(3, 8'h01); push_n(2, 8'h00);
        run_q("dbuf_a", 10);
        bus.duty[0 +: W] = 8'd7;
        push_n(5, 8'h00); push_n(7, 8'h01); push_n(3, 8'h00);
        run_q("dbuf_b", 10);
        bus.duty[0 +: W] = 8'd12;
        push_n(7, 8'h01); push_n(3, 8'h00); push_n(9, 8'h01);
        run_q("dbuf_c", 10);
        bus.duty[0 +: W] = 8'd0;
        push_n(1, 8'h01); push_n(10, 8'h00);
        run_q("dbuf_d", 10);

        // Pin7 static/invert/enable/routing table.
        clear_cfg();
        top_c[1] = 3; duty_c[2] = 0; duty_c[3] = 9;
        apply_cfg();
        for (int i = 0; i < 8; i++) begin
            bus.gen_en     = {tbl[i].g1_en, 1'b0};
            bus.out_en[7]  = tbl[i].en;
            bus.out_pwm_en[7] = tbl[i].pwm;
            bus.out_inv[7] = tbl[i].inv;
            bus.out_sel[SW*7 +: SW] = 2'(tbl[i].sel);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check($sformatf("pin7_row%0d", i), 32'(bus.out), 32'({tbl[i].exp, 7'b0}));
        end

`ifdef PWM_CENTER_ALIGN_EN
        // Center-aligned: 0,1,2,3,4,3,2,1 with duty 2.
        clear_cfg();
        mode_c[0] = 1'b1; top_c[0] = 4; duty_c[0] = 2; en_c[0] = 1'b1;
        bus.out_en = 8'h01; bus.out_pwm_en = 8'h01;
        start_seg();
        for (int m = 1; m <= 16; m++) begin
            @(posedge clk); #1;
            m_cnt++;
            check("center_out", 32'(bus.out), 32'(cseq[(m - 1) % 8] < 2));
            check("center_tick", 32'(bus.period_tick[0]), 32'((m % 8) == 1));
        end
`endif

        // Randomized segments against the model.
        for (int s = 0; s < 10; s++) begin
            for (int g = 0; g < NG; g++) begin
                div_c[g] = $urandom_range(0, 2);
                top_c[g] = $urandom_range(0, 6);
                en_c[g]  = 1'($urandom_range(0, 1));
`ifdef PWM_CENTER_ALIGN_EN
                mode_c[g] = 1'($urandom_range(0, 1));
`else
                mode_c[g] = 1'b0;
`endif
            end
            for (int k = 0; k < NCH; k++) duty_c[k] = $urandom_range(0, 8);
            rand_pins();
            start_seg();
            for (int i = 0; i < 60; i++) begin
                rand_pins();
                step_model("rand");
            end
        end

        // Reset asserted mid-period clears outputs without waiting for a clock.
        clear_cfg();
        top_c[0] = 9; duty_c[0] = 5; en_c[0] = 1'b1;
        bus.out_en = 8'h03; bus.out_pwm_en = 8'h01;
        start_seg();
        for (int i = 0; i < 3; i++) step_model("pre_reset");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out", 32'(bus.out), 32'd0);
        check("midreset_tick", 32'(bus.period_tick), 32'd0);
        @(posedge clk); #1;
        check("midreset_hold_out", 32'(bus.out), 32'd0);
        rst_n = 1'b1;
        start_seg();
        for (int i = 0; i < 20; i++) step_model("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
